haar_stage_evaluator: RTL and testbench

Downstream consumer of the stage-index ROM block: takes one stage's feature index range (start/end) plus that stage's threshold. It walks every feature index in the range, issues one feature-score fetch per index and accumulates the signed scores with saturation. It then reports stage pass/fail to the cascade controller. One stage is evaluated at a time, with one outstanding fetch.

---
 rtl/haar_pkg.sv | 28 ++
 rtl/haar_sat_acc.sv | 51 +++++
 rtl/haar_stage_evaluator.sv | 175 +++++++++++++++++
 tb/tb_haar_stage_evaluator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/haar_pkg.sv
// Shared definitions for the Haar cascade stage evaluator.
// Holds the evaluator state encoding, default bus widths and helpers that
// produce the signed saturation limits for any accumulator width.
package haar_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 15;  // index MSB; index buses are DATA_WIDTH+1 wide
  localparam int unsigned DEF_SCORE_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH   = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } haar_state_e;

  // Bit pattern (low w bits) of the largest positive w-bit signed value.
  function automatic logic [63:0] sat_max_f(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bit pattern (low w bits) of the most negative w-bit signed value.
  function automatic logic [63:0] sat_min_f(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/haar_sat_acc.sv
// Signed saturating accumulator with registered sum.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   clr_i           - clear sum to zero (wins over en_i)
//   en_i            - add sign-extended addend_i into the sum
//   addend_i        - signed addend, IN_WIDTH bits
//   sum_o           - registered signed sum, ACC_WIDTH bits (ACC_WIDTH >= IN_WIDTH)
module haar_sat_acc
  import haar_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_SCORE_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [IN_WIDTH-1:0]  addend_i,
  output logic [ACC_WIDTH-1:0] sum_o
);

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max_f(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min_f(ACC_WIDTH));

  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [ACC_WIDTH:0]   add_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 ovf;

  // One guard bit: overflow when the two top bits of the widened sum differ.
  always_comb begin
    add_ext = (ACC_WIDTH + 1)'($signed(addend_i));
    sum_ext = {sum_q[ACC_WIDTH-1], sum_q} + add_ext;
    ovf     = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    sum_d   = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (en_i) begin
      if (ovf) sum_d = sum_ext[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
      else     sum_d = sum_ext[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/haar_stage_evaluator.sv
// Haar cascade stage evaluator: walks feature indices index_start..index_end
// (inclusive, wrapping modulo 2^(DATA_WIDTH+1)), fetches one score per index
// with a single outstanding fetch, saturating-accumulates the signed scores
// and reports pass = (sum >= threshold) with a one-cycle done pulse.
// Optional build macro HAAR_STAGE_RANGE_CHECK_EN: a start with
// index_end < index_start issues no fetch and finishes with range_err=1.
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   start, index_start, index_end,
//   stage_threshold                 - stage request, sampled in IDLE only
//   feature_rden, feature_addr      - registered fetch strobe / index
//   feature_valid, feature_score    - fetch response (used only in WAIT)
//   busy, done, pass, score,
//   range_err                       - registered status and held result
module haar_stage_evaluator
  import haar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH:0]    index_start,
  input  logic [DATA_WIDTH:0]    index_end,
  input  logic [SCORE_WIDTH-1:0] stage_threshold,
  output logic                   feature_rden,
  output logic [DATA_WIDTH:0]    feature_addr,
  input  logic                   feature_valid,
  input  logic [SCORE_WIDTH-1:0] feature_score,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ACC_WIDTH-1:0]   score,
  output logic                   range_err
);

  localparam int unsigned IDX_W = DATA_WIDTH + 1;

  haar_state_e            state_q, state_d;
  logic [IDX_W-1:0]       cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]       end_q, end_d;
  logic [SCORE_WIDTH-1:0] thr_q, thr_d;
  logic                   err_pend_q, err_pend_d;
  logic                   rden_q, rden_d;
  logic [IDX_W-1:0]       addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [ACC_WIDTH-1:0]   score_q, score_d;
  logic                   rerr_q, rerr_d;
  logic                   acc_clr_c, acc_en_c, range_bad_c;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [ACC_WIDTH-1:0]   thr_ext;

`ifdef HAAR_STAGE_RANGE_CHECK_EN
  assign range_bad_c = index_end < index_start;
`else
  assign range_bad_c = 1'b0;
`endif

  haar_sat_acc #(
    .IN_WIDTH (SCORE_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (acc_clr_c),
    .en_i    (acc_en_c),
    .addend_i(feature_score),
    .sum_o   (acc_sum)
  );

  assign thr_ext = ACC_WIDTH'($signed(thr_q));

  // Next state; registered outputs are derived from the next state so they
  // line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    end_d      = end_q;
    thr_d      = thr_q;
    err_pend_d = err_pend_q;
    pass_d     = pass_q;
    score_d    = score_q;
    rerr_d     = rerr_q;
    acc_clr_c  = 1'b0;
    acc_en_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          end_d      = index_end;
          thr_d      = stage_threshold;
          cur_idx_d  = index_start;
          acc_clr_c  = 1'b1;
          pass_d     = 1'b0;
          score_d    = '0;
          rerr_d     = 1'b0;
          err_pend_d = range_bad_c;
          // A bad range skips the walk and finishes through COMPARE.
          state_d    = range_bad_c ? ST_COMPARE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (feature_valid) begin
          acc_en_c = 1'b1;
          if (cur_idx_q == end_q) begin
            state_d = ST_COMPARE;
          end else begin
            cur_idx_d = cur_idx_q + IDX_W'(1);
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_COMPARE: begin
        state_d = ST_DONE;
        if (err_pend_q) begin
          pass_d  = 1'b0;
          score_d = '0;
          rerr_d  = 1'b1;
        end else begin
          pass_d  = $signed(acc_sum) >= $signed(thr_ext);
          score_d = acc_sum;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rden_d = (state_d == ST_ISSUE);
    addr_d = (state_d == ST_ISSUE) ? cur_idx_d : addr_q;
    busy_d = state_d inside {ST_ISSUE, ST_WAIT, ST_COMPARE};
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_idx_q  <= '0;
      end_q      <= '0;
      thr_q      <= '0;
      err_pend_q <= 1'b0;
      rden_q     <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      score_q    <= '0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      end_q      <= end_d;
      thr_q      <= thr_d;
      err_pend_q <= err_pend_d;
      rden_q     <= rden_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      score_q    <= score_d;
      rerr_q     <= rerr_d;
    end
  end

  assign feature_rden = rden_q;
  assign feature_addr = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign score        = score_q;
  assign range_err    = rerr_q;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Directed bench for haar_stage_evaluator with a latency-programmable score
// responder. Cycle numbering: start is high in cycle 0, cycle n is observed
// at the falling edge after the n-th rising edge.
module tb_haar_stage_evaluator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] index_start, index_end;
  logic [15:0] stage_threshold;
  logic        feature_rden;
  logic [15:0] feature_addr;
  logic        feature_valid;
  logic [15:0] feature_score;
  logic        busy, done, pass, range_err;
  logic [23:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  // responder state
  logic [15:0] addr_log[$];
  int          rden_cnt = 0;
  int          f_idx = 0;
  int          pend = 0;
  int          lat_tab[8];
  logic [15:0] score_tab[8];
  int          n_fill = 0;
  logic [15:0] fill_score = '0;
  logic [15:0] next_score = '0;

  int dc, bc, fr;
  logic clr1;

  always #5 clk = ~clk;

  haar_stage_evaluator dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .index_start    (index_start),
    .index_end      (index_end),
    .stage_threshold(stage_threshold),
    .feature_rden   (feature_rden),
    .feature_addr   (feature_addr),
    .feature_valid  (feature_valid),
    .feature_score  (feature_score),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .score          (score),
    .range_err      (range_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prep();
    for (int i = 0; i < 8; i++) begin
      lat_tab[i]   = 1;
      score_tab[i] = '0;
    end
    n_fill     = 0;
    fill_score = '0;
  endtask

  // Fetch responder: answers each rden after lat_tab[fetch] cycles.
  initial begin
    feature_valid = 1'b0;
    feature_score = '0;
    forever begin
      @(negedge clk);
      feature_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          feature_valid = 1'b1;
          feature_score = next_score;
        end
      end
      if (feature_rden === 1'b1) begin
        addr_log.push_back(feature_addr);
        rden_cnt++;
        if (f_idx < n_fill) next_score = fill_score;
        else                next_score = score_tab[(f_idx - n_fill) & 7];
        pend = (f_idx < 8) ? lat_tab[f_idx] : 1;
        f_idx++;
      end
    end
  end

  // Starts a stage at a falling edge and runs until done or the budget expires.
  // poke: cycle at which a spurious start with a different range is driven.
  task automatic run_stage(input logic [15:0] s, input logic [15:0] e, input logic [15:0] thr,
                           input int poke, output int done_cyc, output int busy_cyc,
                           output int first_rden, output logic clr_ok);
    int cyc;
    addr_log.delete();
    rden_cnt = 0;
    f_idx    = 0;
    index_start = s; index_end = e; stage_threshold = thr; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    cyc = 1; done_cyc = -1; busy_cyc = 0; first_rden = -1; clr_ok = 1'b0;
    while (cyc < 3000) begin
      if (cyc == 1) clr_ok = (pass === 1'b0) && (score === 24'd0);
      if (busy === 1'b1) busy_cyc++;
      if (feature_rden === 1'b1 && first_rden < 0) first_rden = cyc;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == poke) begin
        start = 1'b1; index_start = 16'd40; index_end = 16'd50; stage_threshold = 16'h7FFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0;
    index_start = '0; index_end = '0; stage_threshold = '0;
    prep();
    repeat (3) @(negedge clk);
    check("rst_rden", 64'(feature_rden), 64'd0);
    check("rst_addr", 64'(feature_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_rerr", 64'(range_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: single feature 5..5, score 10 vs threshold 10
    prep(); score_tab[0] = 16'd10;
    run_stage(16'd5, 16'd5, 16'd10, -1, dc, bc, fr, clr1);
    check("t1_done_cyc", 64'(dc), 64'd4);
    check("t1_first_rden", 64'(fr), 64'd1);
    check("t1_busy_cyc", 64'(bc), 64'd3);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_score", 64'(score), 64'd10);
    check("t1_rden_cnt", 64'(rden_cnt), 64'd1);
    check("t1_addr0", 64'(addr_log.size() > 0 ? addr_log[0] : 16'hDEAD), 64'd5);
    check("t1_rerr", 64'(range_err), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_pass_held", 64'(pass), 64'd1);
    check("t1_addr_held", 64'(feature_addr), 64'd5);

    // T2: back-to-back start, 0..2 scores 4,-1,3 threshold 6
    prep(); score_tab[0] = 16'd4; score_tab[1] = 16'hFFFF; score_tab[2] = 16'd3;
    run_stage(16'd0, 16'd2, 16'd6, -1, dc, bc, fr, clr1);
    check("t2_clear_on_start", 64'(clr1), 64'd1);
    check("t2_done_cyc", 64'(dc), 64'd8);
    check("t2_busy_cyc", 64'(bc), 64'd7);
    check("t2_score", 64'(score), 64'd6);
    check("t2_pass", 64'(pass), 64'd1);
    check("t2_rden_cnt", 64'(rden_cnt), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_addr%0d", i), 64'(addr_log.size() > i ? addr_log[i] : 16'hDEAD), 64'(i));
    @(negedge clk);

    // T3: 10..11 scores -5,2 threshold 0, latencies 3 then 1
    prep(); score_tab[0] = 16'hFFFB; score_tab[1] = 16'd2; lat_tab[0] = 3;
    run_stage(16'd10, 16'd11, 16'd0, -1, dc, bc, fr, clr1);
    check("t3_done_cyc", 64'(dc), 64'd8);
    check("t3_score", 64'(score), 64'hFFFFFD);
    check("t3_pass", 64'(pass), 64'd0);
    check("t3_rden_cnt", 64'(rden_cnt), 64'd2);
    check("t3_addr1", 64'(addr_log.size() > 1 ? addr_log[1] : 16'hDEAD), 64'd11);
    @(negedge clk);

    // T4: negative sum equal to negative threshold passes (signed >=)
    prep(); score_tab[0] = 16'hFFFC; score_tab[1] = 16'd2;
    run_stage(16'd3, 16'd4, 16'hFFFE, -1, dc, bc, fr, clr1);
    check("t4_done_cyc", 64'(dc), 64'd6);
    check("t4_score", 64'(score), 64'hFFFFFE);
    check("t4_pass", 64'(pass), 64'd1);
    @(negedge clk);

    // T5: 260 x 32767 clamps at +max, then -1 subtracts from the clamp
    prep(); n_fill = 260; fill_score = 16'h7FFF; score_tab[0] = 16'hFFFF;
    run_stage(16'd0, 16'd260, 16'h7FFF, -1, dc, bc, fr, clr1);
    check("t5_done_cyc", 64'(dc), 64'd524);
    check("t5_score", 64'(score), 64'h7FFFFE);
    check("t5_pass", 64'(pass), 64'd1);
    check("t5_rden_cnt", 64'(rden_cnt), 64'd261);
    @(negedge clk);

    // T6: 300 x -32768 clamps at -2^23, fails threshold -32768
    prep(); n_fill = 300; fill_score = 16'h8000;
    run_stage(16'd100, 16'd399, 16'h8000, -1, dc, bc, fr, clr1);
    check("t6_done_cyc", 64'(dc), 64'd602);
    check("t6_score", 64'(score), 64'h800000);
    check("t6_pass", 64'(pass), 64'd0);
    @(negedge clk);

`ifdef HAAR_STAGE_RANGE_CHECK_EN
    // T7: end < start is rejected without any fetch
    prep();
    run_stage(16'd8, 16'd3, 16'd0, -1, dc, bc, fr, clr1);
    check("t7_done_cyc", 64'(dc), 64'd2);
    check("t7_rden_cnt", 64'(rden_cnt), 64'd0);
    check("t7_rerr", 64'(range_err), 64'd1);
    check("t7_pass", 64'(pass), 64'd0);
    check("t7_score", 64'(score), 64'd0);
`else
    // T7: end < start wraps 65534,65535,0,1
    prep(); n_fill = 4; fill_score = 16'd1;
    run_stage(16'd65534, 16'd1, 16'd4, -1, dc, bc, fr, clr1);
    check("t7_done_cyc", 64'(dc), 64'd10);
    check("t7_rden_cnt", 64'(rden_cnt), 64'd4);
    check("t7_addr0", 64'(addr_log.size() > 0 ? addr_log[0] : 16'hDEAD), 64'd65534);
    check("t7_addr1", 64'(addr_log.size() > 1 ? addr_log[1] : 16'hDEAD), 64'd65535);
    check("t7_addr2", 64'(addr_log.size() > 2 ? addr_log[2] : 16'hDEAD), 64'd0);
    check("t7_addr3", 64'(addr_log.size() > 3 ? addr_log[3] : 16'hDEAD), 64'd1);
    check("t7_score", 64'(score), 64'd4);
    check("t7_pass", 64'(pass), 64'd1);
    check("t7_rerr", 64'(range_err), 64'd0);
`endif
    @(negedge clk);

    // T8: start during WAIT is ignored; latched range/threshold unchanged
    prep(); score_tab[0] = 16'd1; score_tab[1] = 16'd2;
    run_stage(16'd20, 16'd21, 16'd3, 2, dc, bc, fr, clr1);
    check("t8_done_cyc", 64'(dc), 64'd6);
    check("t8_rden_cnt", 64'(rden_cnt), 64'd2);
    check("t8_addr0", 64'(addr_log.size() > 0 ? addr_log[0] : 16'hDEAD), 64'd20);
    check("t8_addr1", 64'(addr_log.size() > 1 ? addr_log[1] : 16'hDEAD), 64'd21);
    check("t8_score", 64'(score), 64'd3);
    check("t8_pass", 64'(pass), 64'd1);
    check("t8_rerr", 64'(range_err), 64'd0);
    @(negedge clk);
    check("t8_idle_after", 64'(busy), 64'd0);

    // T9: reset in WAIT aborts with no done; late response is ignored
    prep(); lat_tab[0] = 20; score_tab[0] = 16'd5;
    addr_log.delete(); rden_cnt = 0; f_idx = 0;
    index_start = 16'd0; index_end = 16'd3; stage_threshold = 16'd0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("t9_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("t9_busy_rst", 64'(busy), 64'd0);
    check("t9_pass_rst", 64'(pass), 64'd0);
    check("t9_score_rst", 64'(score), 64'd0);
    check("t9_addr_rst", 64'(feature_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("t9_no_done", 64'(done_seen), 64'd0);
    check("t9_rden_cnt", 64'(rden_cnt), 64'd1);
    check("t9_score_idle", 64'(score), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
